// File: rtl/gen_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gen_pkg
//  Description : Shared types and constants for the generator sequencer
//                and its helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package gen_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_WAIT  = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    // Source select encoding
    localparam logic c_SEL_FIB = 1'b0;
    localparam logic c_SEL_TIM = 1'b1;

    // Default generator datapath width
    localparam int c_DATA_W = 16;

endpackage : gen_pkg
`default_nettype wire

// File: rtl/gen_sequencer_tick_prescaler.sv
`default_nettype none
// ============================================================================
//  Module      : tick_prescaler
//  Description : Free-running divider producing a one-cycle tick every
//                TICK_DIV clocks while run is high; held at zero otherwise.
//  Revision    : 1.0 - initial release
// ============================================================================
module tick_prescaler #(
    parameter int unsigned TICK_DIV = 5000000
) (
    input  logic clk,
    input  logic rst,      // asynchronous, active-low
    input  logic clear,
    input  logic run,
    output logic tick
);

    localparam logic [31:0] c_LAST = 32'(TICK_DIV - 1);

    logic [31:0] r_count;

    // Divider count: restarts on clear, parks at zero when not running
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= 32'd0;
        end else if (clear || !run) begin
            r_count <= 32'd0;
        end else if (r_count == c_LAST) begin
            r_count <= 32'd0;
        end else begin
            r_count <= r_count + 32'd1;
        end
    end

    assign tick = run && (r_count == c_LAST);

endmodule : tick_prescaler
`default_nettype wire

// File: rtl/gen_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : gen_sequencer
//  Description : Steps the fibonacci or timer generator on a slow tick,
//                captures the selected source's response onto one display
//                bus, and flags missing responses and fibonacci wrap.
//  Revision    : 1.0 - initial release
// ============================================================================
module gen_sequencer
    import gen_pkg::*;
#(
    parameter int unsigned TICK_DIV = 5000000,
    parameter int unsigned TIMEOUT  = 8,
    parameter int          DATA_W   = c_DATA_W
) (
    input  logic              clk,
    input  logic              rst,        // asynchronous, active-low
    input  logic              start,
    input  logic              stop,
    input  logic              sel,
    input  logic              fib_valid,
    input  logic [DATA_W-1:0] fib_data,
    input  logic              tim_valid,
    input  logic [DATA_W-1:0] tim_data,
    output logic              fib_en,
    output logic              tim_en,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              active_sel,
    output logic              busy,
    output logic              error,
    output logic              wrap
);

    localparam logic [7:0] c_TO_LAST = 8'(TIMEOUT - 1);

    state_t              r_state;
    state_t              w_next_state;
    logic [7:0]          r_to_cnt;
    logic [7:0]          w_to_cnt_nxt;
    logic                r_fib_en;
    logic                r_tim_en;
    logic [DATA_W-1:0]   r_data_out;
    logic                r_data_valid;
    logic                r_active_sel;
    logic                r_busy;
    logic                r_error;
    logic                r_wrap;
    logic [DATA_W-1:0]   r_prev;
    logic                r_have_prev;

    logic                w_tick;
    logic                w_run;
    logic                w_accept;
    logic                w_capture;
    logic                w_fib_en;
    logic                w_tim_en;
    logic                w_act_valid;
    logic [DATA_W-1:0]   w_act_data;

    assign w_run       = (r_state == ST_RUN) || (r_state == ST_WAIT);
    assign w_act_valid = (r_active_sel == c_SEL_TIM) ? tim_valid : fib_valid;
    assign w_act_data  = (r_active_sel == c_SEL_TIM) ? tim_data  : fib_data;

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk   (clk),
        .rst   (rst),
        .clear (w_accept),
        .run   (w_run),
        .tick  (w_tick)
    );

    // Next-state, enable request and capture decisions
    always_comb begin
        w_next_state = r_state;
        w_to_cnt_nxt = r_to_cnt;
        w_accept     = 1'b0;
        w_capture    = 1'b0;
        w_fib_en     = 1'b0;
        w_tim_en     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // stop has priority over start
                if (start && !stop) begin
                    w_next_state = ST_RUN;
                    w_accept     = 1'b1;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    w_next_state = ST_IDLE;
                end else if (w_tick) begin
                    w_next_state = ST_WAIT;
                    w_to_cnt_nxt = 8'd0;
                    w_fib_en     = (r_active_sel == c_SEL_FIB);
                    w_tim_en     = (r_active_sel == c_SEL_TIM);
                end
            end
            ST_WAIT: begin
                // A response arriving with stop is still captured
                if (w_act_valid) begin
                    w_capture    = 1'b1;
                    w_next_state = stop ? ST_IDLE : ST_RUN;
                end else if (stop) begin
                    w_next_state = ST_IDLE;
                end else if (r_to_cnt == c_TO_LAST) begin
                    w_next_state = ST_FAULT;
                end else begin
                    w_to_cnt_nxt = r_to_cnt + 8'd1;
                end
            end
            ST_FAULT: begin
                if (stop) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // State, registered outputs, capture and wrap tracking
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_to_cnt     <= 8'd0;
            r_fib_en     <= 1'b0;
            r_tim_en     <= 1'b0;
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
            r_active_sel <= 1'b0;
            r_busy       <= 1'b0;
            r_error      <= 1'b0;
            r_wrap       <= 1'b0;
            r_prev       <= '0;
            r_have_prev  <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_to_cnt     <= w_to_cnt_nxt;
            r_fib_en     <= w_fib_en;
            r_tim_en     <= w_tim_en;
            r_data_valid <= w_capture;
            r_busy       <= (w_next_state == ST_RUN) || (w_next_state == ST_WAIT);
            r_error      <= (w_next_state == ST_FAULT);
            if (w_accept) begin
                r_active_sel <= sel;
                r_wrap       <= 1'b0;
                r_have_prev  <= 1'b0;
            end
            if (w_capture) begin
                r_data_out <= w_act_data;
                // Wrap only tracks the fibonacci source; first capture seeds r_prev
                if (r_active_sel == c_SEL_FIB) begin
                    if (r_have_prev && (w_act_data < r_prev)) begin
                        r_wrap <= 1'b1;
                    end
                    r_prev      <= w_act_data;
                    r_have_prev <= 1'b1;
                end
            end
        end
    end

    assign fib_en     = r_fib_en;
    assign tim_en     = r_tim_en;
    assign data_out   = r_data_out;
    assign data_valid = r_data_valid;
    assign active_sel = r_active_sel;
    assign busy       = r_busy;
    assign error      = r_error;
    assign wrap       = r_wrap;

endmodule : gen_sequencer
`default_nettype wire

// File: tb/tb_gen_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gen_sequencer
//  Description : Self-checking bench for gen_sequencer with generator stubs
//                and a time-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gen_sequencer;

    localparam int TDIV = 4;
    localparam int TOUT = 3;

    localparam int M_IDLE  = 0;
    localparam int M_BUSY  = 1;
    localparam int M_FAULT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        stop;
    logic        sel;
    logic        fib_valid;
    logic [15:0] fib_data;
    logic        tim_valid;
    logic [15:0] tim_data;
    logic        fib_en;
    logic        tim_en;
    logic [15:0] data_out;
    logic        data_valid;
    logic        active_sel;
    logic        busy;
    logic        error;
    logic        wrap;

    gen_sequencer #(
        .TICK_DIV (TDIV),
        .TIMEOUT  (TOUT),
        .DATA_W   (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .sel        (sel),
        .fib_valid  (fib_valid),
        .fib_data   (fib_data),
        .tim_valid  (tim_valid),
        .tim_data   (tim_data),
        .fib_en     (fib_en),
        .tim_en     (tim_en),
        .data_out   (data_out),
        .data_valid (data_valid),
        .active_sel (active_sel),
        .busy       (busy),
        .error      (error),
        .wrap       (wrap)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model state (time-stamp based)
    int          m_mode;
    bit          m_wait;
    int          m_start;
    int          m_en_cyc;
    bit          m_act;
    bit          m_fib_en, m_tim_en, m_dv, m_wrap, m_have;
    logic [15:0] m_data, m_prev;

    // Generator stub controls
    logic [15:0] fib_q[$];
    int          f_pend, t_pend;
    int          delay;        // cycles from enable to valid, 0 = never answers
    bit          rand_delay;
    bit          spam;
    bit          noise;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_mode = M_IDLE; m_wait = 0; m_start = 0; m_en_cyc = 0; m_act = 0;
        m_fib_en = 0; m_tim_en = 0; m_dv = 0; m_wrap = 0; m_have = 0;
        m_data = 16'd0; m_prev = 16'd0;
    endtask

    // Advance the model across one clock edge using the inputs of cycle c
    task automatic model_step();
        int          c;
        logic        av;
        logic [15:0] ad;
        c = cyc;
        m_fib_en = 0; m_tim_en = 0; m_dv = 0;
        if (!rst) begin
            model_reset();
            return;
        end
        case (m_mode)
            M_IDLE: begin
                if (start && !stop) begin
                    m_mode = M_BUSY; m_wait = 0; m_start = c + 1;
                    m_act = sel; m_wrap = 0; m_have = 0;
                end
            end
            M_BUSY: begin
                if (!m_wait) begin
                    if (stop) m_mode = M_IDLE;
                    else if ((c - m_start) % TDIV == TDIV - 1) begin
                        m_wait = 1; m_en_cyc = c + 1;
                        if (m_act) m_tim_en = 1; else m_fib_en = 1;
                    end
                end else begin
                    av = m_act ? tim_valid : fib_valid;
                    ad = m_act ? tim_data  : fib_data;
                    if (av) begin
                        m_dv = 1; m_data = ad; m_wait = 0;
                        if (!m_act) begin
                            if (m_have && ad < m_prev) m_wrap = 1;
                            m_prev = ad; m_have = 1;
                        end
                        if (stop) m_mode = M_IDLE;
                    end else if (stop) begin
                        m_mode = M_IDLE;
                    end else if (c + 1 - m_en_cyc >= TOUT) begin
                        m_mode = M_FAULT;
                    end
                end
            end
            default: begin
                if (stop) m_mode = M_IDLE;
            end
        endcase
    endtask

    task automatic stub_clear();
        f_pend = 0; t_pend = 0;
        fib_valid = 0; tim_valid = 0;
    endtask

    // One clock: model, compare, then drive the stub outputs for the new cycle
    task automatic cycle();
        @(posedge clk);
        #1;
        model_step();
        cyc++;
        check_eq("fib_en",     32'(fib_en),     32'(m_fib_en));
        check_eq("tim_en",     32'(tim_en),     32'(m_tim_en));
        check_eq("data_out",   32'(data_out),   32'(m_data));
        check_eq("data_valid", 32'(data_valid), 32'(m_dv));
        check_eq("active_sel", 32'(active_sel), 32'(m_act));
        check_eq("busy",       32'(busy),       32'(m_mode == M_BUSY));
        check_eq("error",      32'(error),      32'(m_mode == M_FAULT));
        check_eq("wrap",       32'(wrap),       32'(m_wrap));
        fib_valid = 0; tim_valid = 0;
        if (spam) begin
            fib_valid = 1; fib_data = 16'hAAAA;
            tim_valid = 1; tim_data = 16'h0005;
        end else begin
            if (f_pend > 0) begin
                f_pend--;
                if (f_pend == 0) begin
                    fib_valid = 1;
                    fib_data  = (fib_q.size() > 0) ? fib_q.pop_front() : 16'($urandom);
                end
            end
            if (t_pend > 0) begin
                t_pend--;
                if (t_pend == 0) begin
                    tim_valid = 1; tim_data = 16'($urandom);
                end
            end
            if (noise && !fib_valid && $urandom_range(0, 9) == 0) begin
                fib_valid = 1; fib_data = 16'($urandom);
            end
            if (noise && !tim_valid && $urandom_range(0, 9) == 0) begin
                tim_valid = 1; tim_data = 16'($urandom);
            end
        end
        if (fib_en) f_pend = rand_delay ? $urandom_range(0, 4) : delay;
        if (tim_en) t_pend = rand_delay ? $urandom_range(0, 4) : delay;
    endtask

    task automatic drive(input logic st, input logic sp, input logic sl);
        start = st; stop = sp; sel = sl;
    endtask

    initial begin
        int  dv_cnt;
        int  en_at, err_at;
        bit  seen;
        rst = 0; fib_data = 0; tim_data = 0;
        delay = 1; rand_delay = 0; spam = 0; noise = 0;
        drive(0, 0, 0);
        stub_clear();
        model_reset();

        // Reset state
        repeat (2) cycle();
        check_eq("rst_data_out", 32'(data_out), 32'd0);
        check_eq("rst_busy",     32'(busy),     32'd0);
        rst = 1;
        cycle();

        // Fibonacci stepping 0,1,1,2,3
        fib_q = '{16'd0, 16'd1, 16'd1, 16'd2, 16'd3};
        drive(1, 0, 0);
        cycle();
        drive(0, 0, 0);
        dv_cnt = 0;
        for (int i = 0; i < 23; i++) begin
            cycle();
            if (data_valid) dv_cnt++;
        end
        check_eq("fib_dv_count", 32'(dv_cnt),   32'd5);
        check_eq("fib_last",     32'(data_out), 32'd3);
        check_eq("fib_busy",     32'(busy),     32'd1);
        drive(0, 1, 0);
        cycle();
        drive(0, 0, 0);
        cycle();

        // Timer selected, both sources answer every cycle
        spam = 1;
        drive(1, 0, 1);
        cycle();
        drive(0, 0, 0);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (fib_en) seen = 1;
        end
        check_eq("tim_no_fib_en", 32'(seen),       32'd0);
        check_eq("tim_active",    32'(active_sel), 32'd1);
        check_eq("tim_data",      32'(data_out),   32'h0005);
        drive(0, 1, 0);
        cycle();
        spam = 0;
        stub_clear();
        drive(0, 0, 0);
        cycle();

        // Timeout to FAULT
        delay = 0;
        drive(1, 0, 0);
        cycle();
        drive(0, 0, 0);
        en_at = -1; err_at = -1;
        for (int i = 0; i < 14; i++) begin
            cycle();
            if (fib_en && en_at < 0) en_at = cyc;
            if (error && err_at < 0) err_at = cyc;
        end
        check_eq("fault_latency", 32'(err_at - en_at), 32'(TOUT));
        check_eq("fault_error",   32'(error), 32'd1);
        drive(1, 0, 0);
        repeat (3) cycle();
        check_eq("fault_start_ignored", 32'(error), 32'd1);
        drive(0, 1, 0);
        cycle();
        drive(0, 0, 0);
        cycle();
        check_eq("fault_cleared", 32'(error), 32'd0);

        // Fibonacci wrap detection and clear on restart
        delay = 1;
        fib_q = '{16'd46368, 16'd9489};
        drive(1, 0, 0);
        cycle();
        drive(0, 0, 0);
        repeat (14) cycle();
        check_eq("wrap_set", 32'(wrap), 32'd1);
        repeat (8) cycle();
        check_eq("wrap_sticky", 32'(wrap), 32'd1);
        drive(0, 1, 0);
        cycle();
        drive(1, 0, 0);
        cycle();
        drive(0, 0, 0);
        cycle();
        check_eq("wrap_cleared", 32'(wrap), 32'd0);

        // stop coinciding with a valid response
        fib_q = '{16'd21};
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            cycle();
            if (fib_valid) seen = 1;
        end
        check_eq("stopv_found", 32'(seen), 32'd1);
        drive(0, 1, 0);
        cycle();
        drive(0, 0, 0);
        check_eq("stopv_data", 32'(data_out),   32'd21);
        check_eq("stopv_dv",   32'(data_valid), 32'd1);
        check_eq("stopv_busy", 32'(busy),       32'd0);
        drive(1, 1, 1);
        repeat (3) cycle();
        check_eq("start_stop_idle", 32'(busy), 32'd0);
        drive(0, 0, 0);
        cycle();

        // Asynchronous reset in the middle of WAIT
        delay = 0;
        drive(1, 0, 0);
        cycle();
        drive(0, 0, 0);
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            cycle();
            if (fib_en) seen = 1;
        end
        check_eq("arst_reach_wait", 32'(seen), 32'd1);
        #2;
        rst = 0;
        #1;
        check_eq("arst_out", 32'({fib_en, tim_en, data_out, data_valid, active_sel, busy, error, wrap}), 32'd0);
        model_reset();
        stub_clear();
        cycle();
        #2;
        rst = 1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            cycle();
            if (fib_en || tim_en) seen = 1;
        end
        check_eq("arst_no_enable", 32'(seen), 32'd0);

        // Randomised traffic
        rand_delay = 1; noise = 1;
        for (int i = 0; i < 2500; i++) begin
            drive(0, 0, 1'($urandom));
            if (busy) begin
                if ($urandom_range(0, 39) == 0) stop = 1;
                if ($urandom_range(0, 3) == 0) start = 1;
            end else if (error) begin
                if ($urandom_range(0, 5) == 0) stop = 1;
                if ($urandom_range(0, 1) == 0) start = 1;
            end else begin
                if ($urandom_range(0, 3) == 0) start = 1;
                if ($urandom_range(0, 7) == 0) stop = 1;
            end
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_gen_sequencer
`default_nettype wire
